// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in, instruction-memory write port out
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a byte-streamed program into instruction memory, holding the CPU meanwhile
module imem_loader #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    imem_loader_if.slave    bus,
    output logic            cpu_hold,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [ADDR_W:0] words_loaded
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] word_idx;
    logic [1:0]       byte_idx;
    logic [23:0]      asm_lo;
    logic [15:0]      idle_cnt;
    logic             hs;
    logic             hdr_bad;
    logic             timed_out;
    logic             last_word;
    logic             start_ok;

    always_comb begin
        hs        = bus.in_ready & bus.in_valid;
        hdr_bad   = {24'd0, bus.in_data} > 32'(DEPTH);
        // Fires on the edge where the idle count would reach TIMEOUT
        timed_out = (TIMEOUT != 0) && !hs && (idle_cnt == 16'(TIMEOUT - 1));
        last_word = (word_idx + CNT_W'(1)) == word_cnt;
        start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
        state_nx  = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_ok) state_nx = S_HDR;
            end
            S_HDR: begin
                if (timed_out)    state_nx = S_ERR;
                else if (hs)      state_nx = hdr_bad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                if (timed_out)                   state_nx = S_ERR;
                else if (hs && byte_idx == 2'd3) state_nx = S_WRITE;
            end
            S_WRITE: state_nx = last_word ? S_DONE : S_DATA;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            bus.in_ready <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            cpu_hold     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            word_cnt     <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            asm_lo       <= '0;
            idle_cnt     <= '0;
        end else begin
            state        <= state_nx;
            // Status outputs are decoded from the next state so they are registered yet current
            bus.in_ready <= (state_nx == S_HDR) || (state_nx == S_DATA);
            busy         <= (state_nx == S_HDR) || (state_nx == S_DATA) || (state_nx == S_WRITE);
            cpu_hold     <= (state_nx == S_HDR) || (state_nx == S_DATA) || (state_nx == S_WRITE)
                            || (state_nx == S_ERR);
            done         <= (state_nx == S_DONE);
            error        <= (state_nx == S_ERR);
            bus.wr_en    <= (state_nx == S_WRITE);

            if (start_ok) begin
                words_loaded <= '0;
                word_idx     <= '0;
                byte_idx     <= '0;
                asm_lo       <= '0;
                idle_cnt     <= '0;
            end

            if (state == S_HDR || state == S_DATA) begin
                idle_cnt <= hs ? 16'd0 : idle_cnt + 16'd1;
            end

            if (state == S_HDR && hs && !hdr_bad) begin
                word_cnt <= (bus.in_data == 8'd0) ? CNT_W'(DEPTH) : CNT_W'(bus.in_data);
            end

            // Only the low three bytes are kept; the fourth goes straight to wr_data
            if (state == S_DATA && hs) begin
                asm_lo   <= {asm_lo[15:0], bus.in_data};
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    bus.wr_data <= {asm_lo, bus.in_data};
                    bus.wr_addr <= word_idx[ADDR_W-1:0];
                end
            end

            if (state == S_WRITE) begin
                word_idx     <= word_idx + CNT_W'(1);
                words_loaded <= words_loaded + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed table and sequence checks for imem_loader
module tb_imem_loader;
    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 8;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            cpu_hold;
    logic            busy;
    logic            done;
    logic            error;
    logic [ADDR_W:0] words_loaded;

    int n_cmp = 0;
    int n_bad = 0;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    logic [ADDR_W-1:0] cap_addr[$];
    logic [31:0]       cap_data[$];
    logic [31:0]       exp_w[$];

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            cap_addr.push_back(bus.wr_addr);
            cap_data.push_back(bus.wr_data);
        end
    end

    typedef struct {
        logic [7:0]  hdr;
        int          nwords;
        logic [95:0] words;
        bit          exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " in_ready"}, 32'(bus.in_ready), 0);
        check({tag, " wr_en"}, 32'(bus.wr_en), 0);
        check({tag, " wr_addr"}, 32'(bus.wr_addr), 0);
        check({tag, " wr_data"}, bus.wr_data, 0);
        check({tag, " cpu_hold"}, 32'(cpu_hold), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " error"}, 32'(error), 0);
        check({tag, " words_loaded"}, 32'(words_loaded), 0);
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " start busy"}, 32'(busy), 1);
        check({tag, " start in_ready"}, 32'(bus.in_ready), 1);
        check({tag, " start cpu_hold"}, 32'(cpu_hold), 1);
        check({tag, " start done"}, 32'(done), 0);
        check({tag, " start error"}, 32'(error), 0);
        check({tag, " start words_loaded"}, 32'(words_loaded), 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
        bit taken;
        int waited;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            start = poke && (g == 0);
            tick();
            start = 1'b0;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        taken  = 1'b0;
        waited = 0;
        while (!taken && waited < 40) begin
            taken = (bus.in_ready === 1'b1);
            tick();
            waited++;
        end
        if (!taken) begin
            n_cmp++;
            n_bad++;
            $display("FAIL handshake: byte 0x%02h not accepted within 40 cycles", b);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_load(input logic [7:0] hdr, input int max_gap, input bit poke);
        int gap;
        bit pk;
        gap = (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
        pk  = poke && ($urandom_range(0, 1) == 1);
        send_byte(hdr, gap, pk);
        foreach (exp_w[i]) begin
            for (int j = 3; j >= 0; j--) begin
                gap = (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
                pk  = poke && ($urandom_range(0, 1) == 1);
                send_byte(exp_w[i][8*j +: 8], gap, pk);
            end
        end
    endtask

    // Called right after the last data handshake: WRITE is visible now, DONE one cycle later
    task automatic finish_load(input string tag);
        int last;
        last = exp_w.size() - 1;
        check({tag, " last wr_en"}, 32'(bus.wr_en), 1);
        check({tag, " last wr_addr"}, 32'(bus.wr_addr), 32'(last));
        check({tag, " last wr_data"}, bus.wr_data, exp_w[last]);
        check({tag, " hold during write"}, 32'(cpu_hold), 1);
        tick();
        check({tag, " done"}, 32'(done), 1);
        check({tag, " error"}, 32'(error), 0);
        check({tag, " cpu_hold released"}, 32'(cpu_hold), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " in_ready"}, 32'(bus.in_ready), 0);
        check({tag, " wr_en low"}, 32'(bus.wr_en), 0);
        check({tag, " words_loaded"}, 32'(words_loaded), 32'(exp_w.size()));
        check({tag, " write count"}, 32'(cap_addr.size()), 32'(exp_w.size()));
        if (cap_addr.size() == exp_w.size()) begin
            foreach (exp_w[i]) begin
                check($sformatf("%s addr[%0d]", tag, i), 32'(cap_addr[i]), 32'(i));
                check($sformatf("%s data[%0d]", tag, i), cap_data[i], exp_w[i]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h02, 2, {32'hDEADBEEF, 32'h00000013, 32'h0}, 1'b0};
        vecs[1] = '{8'h01, 1, {32'h11223344, 64'h0}, 1'b0};
        vecs[2] = '{8'h03, 3, {32'hA5A5A5A5, 32'h00000000, 32'hFFFFFFFF}, 1'b0};
        vecs[3] = '{8'h41, 0, 96'h0, 1'b1};
        vecs[4] = '{8'hFF, 0, 96'h0, 1'b1};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();
        check_idle_outputs("idle");

        for (int i = 0; i < 5; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            cap_addr.delete();
            cap_data.delete();
            exp_w.delete();
            for (int w = 0; w < vecs[i].nwords; w++) begin
                exp_w.push_back(vecs[i].words[95 - 32*w -: 32]);
            end
            do_start(tag);
            if (vecs[i].exp_err) begin
                send_byte(vecs[i].hdr, 0, 1'b0);
                check({tag, " error"}, 32'(error), 1);
                check({tag, " in_ready"}, 32'(bus.in_ready), 0);
                check({tag, " cpu_hold"}, 32'(cpu_hold), 1);
                check({tag, " busy"}, 32'(busy), 0);
                tick();
                tick();
                tick();
                check({tag, " error held"}, 32'(error), 1);
                check({tag, " no writes"}, 32'(cap_addr.size()), 0);
            end else begin
                send_load(vecs[i].hdr, 0, 1'b0);
                finish_load(tag);
            end
        end

        // Header 0 means a full 64-word program
        cap_addr.delete();
        cap_data.delete();
        exp_w.delete();
        for (int w = 0; w < 64; w++) exp_w.push_back(32'(w));
        do_start("full");
        send_load(8'h00, 0, 1'b0);
        finish_load("full");

        // Timeout: idle cycles after the second data byte
        cap_addr.delete();
        cap_data.delete();
        do_start("tmo");
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        for (int c = 0; c < TIMEOUT - 1; c++) tick();
        check("tmo error before limit", 32'(error), 0);
        check("tmo busy before limit", 32'(busy), 1);
        tick();
        check("tmo error at limit", 32'(error), 1);
        check("tmo cpu_hold", 32'(cpu_hold), 1);
        check("tmo in_ready", 32'(bus.in_ready), 0);
        tick();
        tick();
        check("tmo cpu_hold held", 32'(cpu_hold), 1);
        check("tmo no writes", 32'(cap_addr.size()), 0);
        exp_w.delete();
        exp_w.push_back(32'h0000002A);
        do_start("tmo reload");
        send_load(8'h01, 0, 1'b0);
        finish_load("tmo reload");

        // Random gaps with stray start pulses during the load
        cap_addr.delete();
        cap_data.delete();
        exp_w.delete();
        exp_w.push_back(32'hCAFEF00D);
        exp_w.push_back(32'h01020304);
        exp_w.push_back(32'h80000001);
        exp_w.push_back(32'h7F7F7F7F);
        do_start("gaps");
        send_load(8'h04, 4, 1'b1);
        finish_load("gaps");

        // Start and reset together: reset wins
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check_idle_outputs("start+reset");

        // Reset after the third data byte, then a clean reload
        do_start("midrst");
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        send_byte(8'h33, 0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("midrst");
        tick();
        check_idle_outputs("midrst idle");
        cap_addr.delete();
        cap_data.delete();
        exp_w.delete();
        exp_w.push_back(32'h11223344);
        do_start("midrst reload");
        send_load(8'h01, 0, 1'b0);
        finish_load("midrst reload");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
